// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ valid/ready producers share one sync FIFO write port,
// one producer per grant, bursts bounded to MAX_BURST words, FIFO full used as back-pressure.
`timescale 1ns/1ps
module sync_fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_write_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic                          grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  logic [0:0]            state;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       winner;
  logic [CNT_W-1:0]      burst_cnt;
  logic                  any_req;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  release_grant;

  // First requester at or after last_grant+1, wrapping modulo NUM_REQ (not a power of two in general)
  always_comb begin
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid_i[ID_W'(idx)]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_id_o == ID_W'(k)) begin
        cur_valid = req_valid_i[k];
        cur_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready_o    = '0;
    fifo_write_o   = 1'b0;
    fifo_wr_data_o = '0;
    if (state == GRANT) begin
      req_ready_o[grant_id_o] = !fifo_full_i;
      fifo_write_o            = cur_valid & !fifo_full_i;
      fifo_wr_data_o          = cur_data;
    end
  end

  // A stall on full holds the grant; only a dropped valid or the final burst word releases it
  assign release_grant = !cur_valid || (fifo_write_o && (burst_cnt == BURST_LAST));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      grant_valid_o <= 1'b0;
      grant_id_o    <= '0;
      last_grant    <= LAST_ID;
      burst_cnt     <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        state         <= GRANT;
        grant_valid_o <= 1'b1;
        grant_id_o    <= winner;
        last_grant    <= winner;
        burst_cnt     <= '0;
      end
    end else begin
      if (release_grant) begin
        state         <= IDLE;
        grant_valid_o <= 1'b0;
      end else if (fifo_write_o) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: queue-driven producers, per-source expected-word and
// expected-grant scoreboards, directed cycle patterns and a random run into a depth-8 FIFO model.
`timescale 1ns/1ps
module tb_sync_fifo_wr_arbiter;

  localparam int NR     = 4;
  localparam int DW     = 32;
  localparam int MB     = 4;
  localparam int FDEPTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic [NR-1:0]    req_valid_i = '0;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR-1:0]    req_ready_o;
  logic             fifo_full_i = 1'b0;
  logic             fifo_write_o;
  logic [DW-1:0]    fifo_wr_data_o;
  logic             grant_valid_o;
  logic [1:0]       grant_id_o;

  sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .fifo_full_i    (fifo_full_i),
    .fifo_write_o   (fifo_write_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .grant_valid_o  (grant_valid_o),
    .grant_id_o     (grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] send_q[NR][$];
  logic [31:0] exp_q[NR][$];
  int          exp_grant[$];
  int          seq[NR];
  logic [NR-1:0] acc = '0;
  logic [NR-1:0] hold = '0;
  logic        wr_seen = 1'b0;
  logic        prev_gv = 1'b0;
  logic        gchk_en = 1'b1;
  logic        fifo_mode = 1'b0;
  logic        full_ctl = 1'b0;
  int          fcount = 0;
  int          wr_total = 0;
  int          pushed_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic bit_at(input string s, input int i);
    return s[i] == 8'h31;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int k = 0; k < NR; k++) n += send_q[k].size();
    return n;
  endfunction

  task automatic push_words(input int k, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = (32'(k) << 24) | 32'(seq[k]);
      seq[k]++;
      send_q[k].push_back(w);
      exp_q[k].push_back(w);
      pushed_total++;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid_i[k] = (send_q[k].size() > 0) && !hold[k];
      req_data_i[k*DW +: DW] = (send_q[k].size() > 0) ? send_q[k][0] : '0;
    end
    fifo_full_i = fifo_mode ? (fcount >= FDEPTH) : full_ctl;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NR; k++)
      if (acc[k] && send_q[k].size() > 0) void'(send_q[k].pop_front());
    if (fifo_mode) begin
      if (wr_seen) begin
        fcount++;
        check_eq("fifo_overflow", 64'(fcount <= FDEPTH), 1);
      end
      if (fcount > 0 && $urandom_range(1, 0) == 1) fcount--;
    end
    drive();
  endtask

  task automatic do_reset();
    check_eq("grants_left", 64'(exp_grant.size()), 0);
    rst_n_i   = 1'b0;
    hold      = '0;
    full_ctl  = 1'b0;
    fifo_mode = 1'b0;
    fcount    = 0;
    gchk_en   = 1'b1;
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  // Pattern strings are indexed by cycle after arbitration starts (cycle 0 = IDLE with requests)
  task automatic run_pattern(input string name, input string full_p, input string hold_p,
                             input string gv_p, input string wr_p);
    for (int c = 0; c < gv_p.len(); c++) begin
      full_ctl = bit_at(full_p, c);
      hold[0]  = bit_at(hold_p, c);
      drive();
      check_eq($sformatf("%s_gv_c%0d", name, c), grant_valid_o, bit_at(gv_p, c));
      check_eq($sformatf("%s_wr_c%0d", name, c), fifo_write_o, bit_at(wr_p, c));
      if (full_ctl) check_eq($sformatf("%s_rdy_stall_c%0d", name, c), req_ready_o, 0);
      step();
    end
    hold     = '0;
    full_ctl = 1'b0;
    drive();
  endtask

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      acc     = '0;
      wr_seen = 1'b0;
      prev_gv = 1'b0;
    end else begin
      acc     = req_valid_i & req_ready_o;
      wr_seen = fifo_write_o;
      if (fifo_full_i) check_eq("wr_while_full", fifo_write_o, 0);
      for (int k = 0; k < NR; k++)
        if (!(grant_valid_o && grant_id_o == 2'(k)))
          check_eq($sformatf("ready_ungranted_%0d", k), req_ready_o[k], 0);
      if (fifo_write_o) begin
        wr_total++;
        check_eq("sb_word_expected", 64'(exp_q[grant_id_o].size() > 0), 1);
        if (exp_q[grant_id_o].size() > 0)
          check_eq($sformatf("sb_data_src%0d", grant_id_o), fifo_wr_data_o,
                   exp_q[grant_id_o].pop_front());
      end
      if (grant_valid_o && !prev_gv && gchk_en) begin
        check_eq("grant_expected", 64'(exp_grant.size() > 0), 1);
        if (exp_grant.size() > 0) check_eq("grant_id", grant_id_o, exp_grant.pop_front());
      end
      prev_gv = grant_valid_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset values while a producer is already requesting
    push_words(1, 6);
    exp_grant = '{1, 1};
    drive();
    step();
    check_eq("rst_gv", grant_valid_o, 0);
    check_eq("rst_gid", grant_id_o, 0);
    check_eq("rst_wr", fifo_write_o, 0);
    check_eq("rst_rdy", req_ready_o, 0);
    check_eq("rst_data", fifo_wr_data_o, 0);
    rst_n_i = 1'b1;
    drive();

    // 1: single producer, 6 words -> burst of 4, idle, burst of 2, release on valid drop
    run_pattern("t1", "0000000000", "0000000000", "0111101110", "0111101100");

    // 2: all producers continuously valid
    do_reset();
    for (int k = 0; k < NR; k++) push_words(k, 8);
    exp_grant = '{0, 1, 2, 3, 0, 1, 2, 3};
    drive();
    n = wr_total;
    repeat (20) step();
    check_eq("t2_words_per_20", 64'(wr_total - n), 16);
    repeat (20) step();
    check_eq("t2_words_per_40", 64'(wr_total - n), 32);
    check_eq("t2_idle_end", grant_valid_o, 0);

    // 3: full stall after producer 2's first word
    do_reset();
    push_words(2, 6);
    exp_grant = '{2, 2};
    run_pattern("t3", "0011100000000", "0000000000000", "0111111101110", "0100011101100");

    // 4: producer 0 drops valid after 2 words; producer 3 must win next
    do_reset();
    push_words(0, 5);
    push_words(3, 4);
    exp_grant = '{0, 3, 0};
    run_pattern("t4", "000000000000000", "000100000000000", "011101111011110", "011001111011100");

    // 5: asynchronous reset mid-burst
    do_reset();
    for (int k = 0; k < NR; k++) push_words(k, 8);
    exp_grant = '{0};
    drive();
    step();
    step();
    #1 rst_n_i = 1'b0;
    #1;
    check_eq("t5_async_gv", grant_valid_o, 0);
    check_eq("t5_async_wr", fifo_write_o, 0);
    check_eq("t5_async_rdy", req_ready_o, 0);
    check_eq("t5_async_data", fifo_wr_data_o, 0);
    step();
    step();
    rst_n_i = 1'b1;
    exp_grant = '{0, 1, 2, 3, 0, 1, 2, 3};
    drive();
    step();
    check_eq("t5_first_gv", grant_valid_o, 1);
    check_eq("t5_first_gid", grant_id_o, 0);
    n = 0;
    while (pending() > 0 && n < 300) begin
      step();
      n++;
    end
    check_eq("t5_drained", 64'(pending()), 0);
    repeat (3) step();

    // 6: random traffic into a depth-8 FIFO model with random reads
    do_reset();
    gchk_en   = 1'b0;
    fifo_mode = 1'b1;
    drive();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(3, 0) == 0 && send_q[k].size() < 6) push_words(k, $urandom_range(3, 1));
        hold[k] = ($urandom_range(9, 0) == 0);
      end
      step();
    end
    hold = '0;
    n = 0;
    while (pending() > 0 && n < 3000) begin
      step();
      n++;
    end
    check_eq("t6_drained", 64'(pending()), 0);
    repeat (3) step();
    for (int k = 0; k < NR; k++)
      check_eq($sformatf("t6_lost_src%0d", k), 64'(exp_q[k].size()), 0);
    check_eq("t6_total_words", 64'(wr_total), 64'(pushed_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
